// File: rtl/tf1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tf1_pkg
// Description : Shared constants, wide arithmetic type and helpers for the
//               first-order transfer-function engine.
// Revision    : 1.0 - initial release
// ============================================================================
package tf1_pkg;

    // Accept-to-result latency in cycles
    localparam int c_lat    = 3;
    // Widest supported data width; the wide type covers a 2W+2-bit sum at W = 64
    localparam int c_max_w  = 64;
    localparam int c_wide_w = 2 * c_max_w + 2;

    typedef logic signed [c_wide_w-1:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  sat;
    } clamp_t;

    // Channel index width, never below one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Drop the fractional bits of a widened sum; arithmetic shift floors
    function automatic wide_t shift_frac(input wide_t sum, input int frac);
        return sum >>> frac;
    endfunction

    // Clamp to [lo, hi]; sat only when the input lies strictly outside
    function automatic clamp_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
        clamp_t r;
        r.value = v;
        r.sat   = 1'b0;
        if (v < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end else if (v > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tf1_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tf1_mac_pipe
// Description : S1-S3 datapath: products, 2W+2-bit sum, floor shift and
//               clamp, with channel/valid/hold/x tags carried alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tf1_mac_pipe
    import tf1_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int CH_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [CH_W-1:0]     i_ch,
    input  logic                i_init,
    input  logic                i_hold,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_x_prev,
    input  logic signed [W-1:0] i_y_prev,
    input  logic signed [W-1:0] i_coef_a,
    input  logic signed [W-1:0] i_coef_b,
    input  logic signed [W-1:0] i_coef_c,
    input  logic signed [W-1:0] i_coef_g,
    input  logic signed [W-1:0] i_y_min,
    input  logic signed [W-1:0] i_y_max,
    output logic                o_valid,
    output logic [CH_W-1:0]     o_ch,
    output logic                o_hold,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_data,
    output logic                o_sat
);

    localparam int c_pw = 2 * W;
    localparam int c_sw = 2 * W + 2;

    logic signed [W-1:0]    w_k_x;
    logic signed [c_pw-1:0] w_p_x;
    logic signed [c_pw-1:0] w_p_b;
    logic signed [c_pw-1:0] w_p_c;

    logic                   r1_valid;
    logic                   r1_hold;
    logic [CH_W-1:0]        r1_ch;
    logic signed [W-1:0]    r1_x;
    logic signed [W-1:0]    r1_y_prev;
    logic signed [c_pw-1:0] r1_p_x;
    logic signed [c_pw-1:0] r1_p_b;
    logic signed [c_pw-1:0] r1_p_c;

    logic                   r2_valid;
    logic                   r2_hold;
    logic [CH_W-1:0]        r2_ch;
    logic signed [W-1:0]    r2_x;
    logic signed [W-1:0]    r2_y_prev;
    logic signed [c_sw-1:0] r2_sum;

    wide_t                  w_shift;
    clamp_t                 w_cl;

    // Init reuses the A multiplier for G*x and silences the history terms
    assign w_k_x = i_init ? i_coef_g : i_coef_a;
    assign w_p_x = c_pw'(w_k_x) * c_pw'(i_x);
    assign w_p_b = i_init ? '0 : c_pw'(i_coef_b) * c_pw'(i_x_prev);
    assign w_p_c = i_init ? '0 : c_pw'(i_coef_c) * c_pw'(i_y_prev);

    // S1: register the three products and the tags
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_hold   <= 1'b0;
            r1_ch     <= '0;
            r1_x      <= '0;
            r1_y_prev <= '0;
            r1_p_x    <= '0;
            r1_p_b    <= '0;
            r1_p_c    <= '0;
        end else begin
            r1_valid  <= i_valid;
            r1_hold   <= i_hold;
            r1_ch     <= i_ch;
            r1_x      <= i_x;
            r1_y_prev <= i_y_prev;
            r1_p_x    <= w_p_x;
            r1_p_b    <= w_p_b;
            r1_p_c    <= w_p_c;
        end
    end

    // S2: register the sign-extended sum and the tags
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid  <= 1'b0;
            r2_hold   <= 1'b0;
            r2_ch     <= '0;
            r2_x      <= '0;
            r2_y_prev <= '0;
            r2_sum    <= '0;
        end else begin
            r2_valid  <= r1_valid;
            r2_hold   <= r1_hold;
            r2_ch     <= r1_ch;
            r2_x      <= r1_x;
            r2_y_prev <= r1_y_prev;
            r2_sum    <= c_sw'(r1_p_x) + c_sw'(r1_p_b) + c_sw'(r1_p_c);
        end
    end

    // S3: floor shift and clamp; the clamped value always fits in W bits
    assign w_shift = shift_frac(wide_t'(r2_sum), FRAC);
    assign w_cl    = clamp(w_shift, wide_t'(i_y_min), wide_t'(i_y_max));

    assign o_valid = r2_valid;
    assign o_ch    = r2_ch;
    assign o_hold  = r2_hold;
    assign o_x     = r2_x;
    assign o_data  = !r2_valid ? '0 : (r2_hold ? r2_y_prev : W'(w_cl.value));
    assign o_sat   = r2_valid & ~r2_hold & w_cl.sat;

endmodule
`default_nettype wire

// File: rtl/tf1_mc_engine.sv
`default_nettype none
// ============================================================================
// Module      : tf1_mc_engine
// Description : Time-multiplexed y = A*x + B*x[n-1] + C*y[n-1] engine for
//               N_CH channels with init, clamp/anti-windup, hold and
//               channel-reuse hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module tf1_mc_engine
    import tf1_pkg::*;
#(
    parameter  int N_CH = 64,
    parameter  int W    = 32,
    parameter  int FRAC = 16,
    localparam int CH_W = ch_w(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] coef_a,
    input  logic signed [W-1:0] coef_b,
    input  logic signed [W-1:0] coef_c,
    input  logic signed [W-1:0] coef_g,
    input  logic signed [W-1:0] y_min,
    input  logic signed [W-1:0] y_max,
    input  logic                init_req,
    input  logic                in_valid,
    input  logic [CH_W-1:0]     in_ch,
    input  logic signed [W-1:0] in_data,
    input  logic                in_hold,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic signed [W-1:0] out_data,
    output logic                out_sat,
    output logic                hazard_err
);

    localparam logic [CH_W:0] c_n_ch = N_CH[CH_W:0];

    logic signed [W-1:0] r_x_prev [N_CH];
    logic signed [W-1:0] r_y_prev [N_CH];
    logic [N_CH-1:0]     r_pend;
    logic [N_CH-1:0]     w_pend_next;
    logic [N_CH-1:0]     w_onehot;

    logic                w_ch_ok;
    logic                w_acc;
    logic                w_upd;
    logic                w_init;

    logic [c_lat-1:0]    r_hist_v;
    logic [CH_W-1:0]     r_hist_ch [c_lat];
    logic [c_lat-1:0]    w_hit;
    logic                r_hazard;

    logic                r_s0_valid;
    logic                r_s0_init;
    logic                r_s0_hold;
    logic [CH_W-1:0]     r_s0_ch;
    logic signed [W-1:0] r_s0_x;
    logic signed [W-1:0] r_s0_xp;
    logic signed [W-1:0] r_s0_yp;
    logic signed [W-1:0] r_s0_ca;
    logic signed [W-1:0] r_s0_cb;
    logic signed [W-1:0] r_s0_cc;
    logic signed [W-1:0] r_s0_cg;

    logic                w_wb_hold;
    logic signed [W-1:0] w_wb_x;

    // Out-of-range channels are dropped; hold samples never touch state
    assign w_ch_ok = {1'b0, in_ch} < c_n_ch;
    assign w_acc   = in_valid & w_ch_ok;
    assign w_upd   = w_acc & ~in_hold;
    assign w_init  = (r_pend[in_ch] | init_req) & ~in_hold;

    // Pending next state: optional re-arm, then clear the channel being updated
    always_comb begin
        w_onehot = '0;
        if (w_upd) begin
            w_onehot[in_ch] = 1'b1;
        end
        w_pend_next = (init_req ? {N_CH{1'b1}} : r_pend) & ~w_onehot;
    end

    // Reuse of any channel still in flight (accepted in the last c_lat cycles)
    for (genvar g = 0; g < c_lat; g++) begin : g_haz
        assign w_hit[g] = r_hist_v[g] && (r_hist_ch[g] == in_ch);
    end

    // Accept history shift register and sticky hazard flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_v <= '0;
            for (int i = 0; i < c_lat; i++) begin
                r_hist_ch[i] <= '0;
            end
            r_hazard <= 1'b0;
        end else begin
            r_hist_v     <= {r_hist_v[c_lat-2:0], w_acc};
            r_hist_ch[0] <= in_ch;
            for (int i = 1; i < c_lat; i++) begin
                r_hist_ch[i] <= r_hist_ch[i-1];
            end
            if ((w_acc && |w_hit) || (in_valid && !w_ch_ok)) begin
                r_hazard <= 1'b1;
            end
        end
    end

    // S0: register the sample, its channel state and the coefficients at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_init  <= 1'b0;
            r_s0_hold  <= 1'b0;
            r_s0_ch    <= '0;
            r_s0_x     <= '0;
            r_s0_xp    <= '0;
            r_s0_yp    <= '0;
            r_s0_ca    <= '0;
            r_s0_cb    <= '0;
            r_s0_cc    <= '0;
            r_s0_cg    <= '0;
        end else begin
            r_s0_valid <= w_acc;
            r_s0_init  <= w_init;
            r_s0_hold  <= in_hold;
            r_s0_ch    <= in_ch;
            r_s0_x     <= in_data;
            r_s0_xp    <= r_x_prev[in_ch];
            r_s0_yp    <= r_y_prev[in_ch];
            r_s0_ca    <= coef_a;
            r_s0_cb    <= coef_b;
            r_s0_cc    <= coef_c;
            r_s0_cg    <= coef_g;
        end
    end

    // Pending bits and per-channel history; write-back stores the clamped y
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '1;
            for (int i = 0; i < N_CH; i++) begin
                r_x_prev[i] <= '0;
                r_y_prev[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_next;
            if (out_valid && !w_wb_hold) begin
                r_x_prev[out_ch] <= w_wb_x;
                r_y_prev[out_ch] <= out_data;
            end
        end
    end

    tf1_mac_pipe #(
        .W    (W),
        .FRAC (FRAC),
        .CH_W (CH_W)
    ) u_mac_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_s0_valid),
        .i_ch     (r_s0_ch),
        .i_init   (r_s0_init),
        .i_hold   (r_s0_hold),
        .i_x      (r_s0_x),
        .i_x_prev (r_s0_xp),
        .i_y_prev (r_s0_yp),
        .i_coef_a (r_s0_ca),
        .i_coef_b (r_s0_cb),
        .i_coef_c (r_s0_cc),
        .i_coef_g (r_s0_cg),
        .i_y_min  (y_min),
        .i_y_max  (y_max),
        .o_valid  (out_valid),
        .o_ch     (out_ch),
        .o_hold   (w_wb_hold),
        .o_x      (w_wb_x),
        .o_data   (out_data),
        .o_sat    (out_sat)
    );

    assign hazard_err = r_hazard;

endmodule
`default_nettype wire

// File: tb/tb_tf1_mc_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_tf1_mc_engine
// Description : Directed self-checking bench for tf1_mc_engine (FRAC = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tf1_mc_engine;

    localparam logic [31:0] c_one  = 32'h0001_0000;
    localparam logic [31:0] c_half = 32'h0000_8000;
    localparam logic [31:0] c_lim  = 32'h0064_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] coef_a, coef_b, coef_c, coef_g;
    logic [31:0] y_min, y_max;
    logic        init_req, in_valid, in_hold;
    logic [5:0]  in_ch;
    logic [31:0] in_data;
    logic        out_valid, out_sat, hazard_err;
    logic [5:0]  out_ch;
    logic [31:0] out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tf1_mc_engine dut (
        .clk        (clk),
        .rst        (rst),
        .coef_a     (coef_a),
        .coef_b     (coef_b),
        .coef_c     (coef_c),
        .coef_g     (coef_g),
        .y_min      (y_min),
        .y_max      (y_max),
        .init_req   (init_req),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .in_hold    (in_hold),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .hazard_err (hazard_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One sample, result checked at accept+3, next accept at accept+4
    task automatic run(input string tag, input int ch, input logic [31:0] x, input logic hold,
                       input logic [31:0] e_data, input logic e_sat);
        in_valid = 1'b1;
        in_ch    = ch[5:0];
        in_data  = x;
        in_hold  = hold;
        tick();
        in_valid = 1'b0;
        in_hold  = 1'b0;
        tick();
        tick();
        check({tag, "/valid"}, 32'(out_valid), 32'd1);
        check({tag, "/ch"},    32'(out_ch),    32'(ch[5:0]));
        check({tag, "/data"},  out_data,       e_data);
        check({tag, "/sat"},   32'(out_sat),   32'(e_sat));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  init_req = 1'b0; in_valid = 1'b0; in_hold = 1'b0;
        in_ch = '0;  in_data = '0;
        coef_a = c_one; coef_b = '0; coef_c = '0; coef_g = 32'h0002_0000;
        y_min = -c_lim; y_max = c_lim;
        tick(); tick(); tick();
        check("rst/valid",  32'(out_valid),  32'd0);
        check("rst/data",   out_data,        32'd0);
        check("rst/ch",     32'(out_ch),     32'd0);
        check("rst/sat",    32'(out_sat),    32'd0);
        check("rst/hazard", 32'(hazard_err), 32'd0);
        rst = 1'b0;
        tick();

        // Init on first sample: 2.0 * 3.0, then normal 1.0 * 1.0
        run("init5", 5, 32'h0003_0000, 1'b0, 32'h0006_0000, 1'b0);
        run("norm5", 5, c_one,         1'b0, c_one,         1'b0);

        // Integrator on ch0: 0, 1.0, 2.0
        coef_a = c_half; coef_b = c_half; coef_c = c_one; coef_g = '0;
        run("int0a", 0, c_one, 1'b0, 32'h0000_0000, 1'b0);
        run("int0b", 0, c_one, 1'b0, 32'h0001_0000, 1'b0);
        run("int0c", 0, c_one, 1'b0, 32'h0002_0000, 1'b0);

        // Hold returns stored 2.0; next sample proves history untouched
        run("hold0", 0, 32'h0005_0000, 1'b1, 32'h0002_0000, 1'b0);
        run("post0", 0, c_one,         1'b0, 32'h0003_0000, 1'b0);

        // Clamp at 1.5 with anti-windup on ch1
        y_max = 32'h0001_8000;
        run("sat1a", 1, c_one,         1'b0, 32'h0000_0000, 1'b0);
        run("sat1b", 1, c_one,         1'b0, 32'h0001_0000, 1'b0);
        run("sat1c", 1, c_one,         1'b0, 32'h0001_8000, 1'b1);
        run("sat1d", 1, 32'hFFFF_0000, 1'b0, 32'h0001_8000, 1'b0);
        y_max = c_lim;

        // Round robin, two frames: frame 1 re-armed -> y = x = k/4,
        // frame 2 x = -k/8 -> y = -k/16 + k/8 + k/4 = 5k/16
        coef_g = c_one;
        for (int k = 0; k < 131; k++) begin
            if (k < 128) begin
                in_valid = 1'b1;
                in_ch    = 6'(k % 64);
                in_data  = (k < 64) ? 32'(k * 32'h4000) : 32'(-((k - 64) * 32'h2000));
                init_req = (k == 0);
            end else begin
                in_valid = 1'b0;
                init_req = 1'b0;
            end
            if (k >= 3) begin
                int j;
                j = k - 3;
                check("rr/valid", 32'(out_valid), 32'd1);
                check("rr/ch",    32'(out_ch),    32'(j % 64));
                check("rr/data",  out_data,
                      (j < 64) ? 32'(j * 32'h4000) : 32'((j - 64) * 32'h5000));
            end
            tick();
        end
        init_req = 1'b0;
        check("rr/hazard", 32'(hazard_err), 32'd0);
        tick();

        // Hazard: ch2 at t and t+2; ch2 state is x=-0.25, y=0.625
        in_valid = 1'b1; in_ch = 6'd2; in_data = c_one;
        tick();
        in_valid = 1'b0;
        check("haz/pre", 32'(hazard_err), 32'd0);
        tick();
        in_valid = 1'b1; in_ch = 6'd2; in_data = c_one;
        tick();
        in_valid = 1'b0;
        check("haz/first_valid", 32'(out_valid),  32'd1);
        check("haz/first_data",  out_data,        32'h0001_0000);
        check("haz/set",         32'(hazard_err), 32'd1);
        tick();
        tick();
        check("haz/stale_valid", 32'(out_valid),  32'd1);
        check("haz/stale_data",  out_data,        32'h0001_0000);
        tick(); tick(); tick(); tick();
        check("haz/sticky", 32'(hazard_err), 32'd1);

        // Full pipeline with init_req, then reset discards in-flight work
        in_valid = 1'b1; in_ch = 6'd10; in_data = c_one;
        tick();
        in_ch = 6'd11; init_req = 1'b1;
        tick();
        in_valid = 1'b0; init_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("flush/valid", 32'(out_valid), 32'd0);
            tick();
        end
        check("flush/hazard", 32'(hazard_err), 32'd0);

        // History cleared by reset, pending re-armed
        coef_a = c_one; coef_b = '0; coef_c = 32'h0000_4000; coef_g = 32'h0002_0000;
        run("rst_hold2", 2, 32'h0007_0000, 1'b1, 32'h0000_0000, 1'b0);
        run("rst_init2", 2, c_one,         1'b0, 32'h0002_0000, 1'b0);
        run("rst_norm2", 2, c_one,         1'b0, 32'h0001_8000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
